matmul_index_sequencer: RTL

Loop-nest sequencer for the matrix-multiply datapath. It walks C[i][j] = Σk A[i][k]·B[k][j] for A (M×N), B (N×P) and C (M×P), all row-major. Each beat it emits the A, B and C word addresses plus accumulator control, using a valid/ready handshake. It sits directly upstream of the address/increment registers and the MAC unit, and supplies the write-enable and increment stimuli they consume.

---
 rtl/matmul_index_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/matmul_index_sequencer.sv
// matmul_index_sequencer: loop-nest address sequencer for C = A x B (row-major).
// Walks i over M, j over P and k over N, with k innermost, and emits one
// A/B/C address beat per accepted valid/ready handshake.
// Optional feature macro: SEQ_ABORT_EN adds the abort input and aborted output.
module matmul_index_sequencer #(
  parameter int WORD_SIZE = 16,
  parameter int DIM_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIM_W-1:0]     dim_m,
  input  logic [DIM_W-1:0]     dim_n,
  input  logic [DIM_W-1:0]     dim_p,
  input  logic [WORD_SIZE-1:0] base_a,
  input  logic [WORD_SIZE-1:0] base_b,
  input  logic [WORD_SIZE-1:0] base_c,
  output logic                 step_valid,
  input  logic                 step_ready,
  output logic [WORD_SIZE-1:0] addr_a,
  output logic [WORD_SIZE-1:0] addr_b,
  output logic [WORD_SIZE-1:0] addr_c,
  output logic                 acc_first,
  output logic                 acc_last,
  output logic                 busy,
  output logic                 done
`ifdef SEQ_ABORT_EN
  ,
  input  logic                 abort,
  output logic                 aborted
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [DIM_W-1:0]     m_q, n_q, p_q;
  logic [DIM_W-1:0]     i_q, j_q, k_q;
  logic [WORD_SIZE-1:0] base_b_q;
  logic [WORD_SIZE-1:0] row_a_q;   // base_a + i*N, kept by accumulation
  logic [WORD_SIZE-1:0] col_b_q;   // base_b + j, kept by accumulation
  logic [WORD_SIZE-1:0] addr_a_q, addr_b_q, addr_c_q;

  logic zero_dim, launch, accept, abort_hit;
  logic k_last, j_last, i_last, final_beat;

  assign zero_dim   = (dim_m == '0) || (dim_n == '0) || (dim_p == '0);
  assign launch     = (state_q == S_IDLE) && start && !zero_dim;
  assign accept     = (state_q == S_RUN) && step_ready;
  assign k_last     = (k_q == n_q - DIM_W'(1));
  assign j_last     = (j_q == p_q - DIM_W'(1));
  assign i_last     = (i_q == m_q - DIM_W'(1));
  assign final_beat = accept && k_last && j_last && i_last;

`ifdef SEQ_ABORT_EN
  logic aborted_q;
  // An abort discards the beat pending at the same edge.
  assign abort_hit = (state_q == S_RUN) && abort;
  assign aborted   = aborted_q;

  // Aborted flag: high only during the DONE cycle that follows an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) aborted_q <= 1'b0;
    else     aborted_q <= abort_hit;
  end
`else
  assign abort_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = zero_dim ? S_DONE : S_RUN;
      S_RUN:  if (abort_hit || final_beat) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Loop counters and address registers: latch on launch, advance on accepted beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q      <= '0;
      n_q      <= '0;
      p_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      base_b_q <= '0;
      row_a_q  <= '0;
      col_b_q  <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_c_q <= '0;
    end else if (launch) begin
      m_q      <= dim_m;
      n_q      <= dim_n;
      p_q      <= dim_p;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      base_b_q <= base_b;
      row_a_q  <= base_a;
      col_b_q  <= base_b;
      addr_a_q <= base_a;
      addr_b_q <= base_b;
      addr_c_q <= base_c;
    end else if (accept && !abort_hit) begin
      if (!k_last) begin
        // Next k: step along the A row and down the B column.
        k_q      <= k_q + DIM_W'(1);
        addr_a_q <= addr_a_q + WORD_SIZE'(1);
        addr_b_q <= addr_b_q + WORD_SIZE'(p_q);
      end else if (!j_last) begin
        // Next column of C: rewind A to the row start, move B to the next column.
        k_q      <= '0;
        j_q      <= j_q + DIM_W'(1);
        addr_a_q <= row_a_q;
        col_b_q  <= col_b_q + WORD_SIZE'(1);
        addr_b_q <= col_b_q + WORD_SIZE'(1);
        addr_c_q <= addr_c_q + WORD_SIZE'(1);
      end else if (!i_last) begin
        // Next row of C: advance the A row start by N, restart B at its base.
        k_q      <= '0;
        j_q      <= '0;
        i_q      <= i_q + DIM_W'(1);
        row_a_q  <= row_a_q + WORD_SIZE'(n_q);
        addr_a_q <= row_a_q + WORD_SIZE'(n_q);
        col_b_q  <= base_b_q;
        addr_b_q <= base_b_q;
        addr_c_q <= addr_c_q + WORD_SIZE'(1);
      end
    end
  end

  assign busy       = (state_q == S_RUN);
  assign step_valid = busy;
  assign done       = (state_q == S_DONE);
  assign acc_first  = busy && (k_q == '0);
  assign acc_last   = busy && k_last;
  assign addr_a     = addr_a_q;
  assign addr_b     = addr_b_q;
  assign addr_c     = addr_c_q;

endmodule
